inf_icache: RTL and testbench

Direct-mapped instruction cache directly upstream of the instruction-fetch stage.
- Serves the fetch stage's ic_enable/iaddr/idata/ic_done handshake with whole 64-byte lines.
- On a miss, fills the line over the 64-bit system bus in 8 read beats, then installs the line and returns it.
- Exactly one ic_done pulse per accepted request. Fetch relies on this even after a redirect.

---
 rtl/inf_pkg.sv | 21 ++
 rtl/inf_icache_array.sv | 45 ++++
 rtl/inf_icache.sv | 190 +++++++++++++++++++
 tb/tb_inf_icache.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inf_pkg.sv
// Shared constants and types for the instruction cache and its bus interface.
package inf_pkg;

   localparam int unsigned LINE_BYTES = 64;
   localparam int unsigned BEATS      = 8;

   localparam logic [2:0]  READ          = 3'b001;
   localparam logic [1:0]  MEMORY        = 2'b01;
   localparam logic [12:0] REQTAG_IFETCH = {READ, MEMORY, 8'h00};

   typedef logic [511:0] line_t;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      FILL_REQ,
      FILL_WAIT,
      FILL_DONE
   } icache_state_t;

endpackage

// File: rtl/inf_icache_array.sv
// Line storage for the direct-mapped instruction cache: data, tag and valid per set.
// Only the valid bits are reset; data and tag contents are qualified by valid.
module inf_icache_array
   import inf_pkg::*;
#(
   parameter int unsigned SETS       = 64,
   parameter int unsigned TAG_W      = 52,
   parameter int unsigned INDEX_BITS = $clog2(SETS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   output line_t                 o_rd_line,
   output logic [TAG_W-1:0]      o_rd_tag,
   output logic                  o_rd_valid,
   input  logic                  i_we,
   input  logic [INDEX_BITS-1:0] i_wr_index,
   input  line_t                 i_wr_line,
   input  logic [TAG_W-1:0]      i_wr_tag
);

   line_t            r_data  [SETS];
   logic [TAG_W-1:0] r_tag   [SETS];
   logic [SETS-1:0]  r_valid;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_data[i_wr_index] <= i_wr_line;
         r_tag[i_wr_index]  <= i_wr_tag;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   assign o_rd_line  = r_data[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_valid = r_valid[i_rd_index];

endmodule

// File: rtl/inf_icache.sv
// Direct-mapped instruction cache returning whole 64-byte lines; misses fill over an 8-beat bus.
// Define INF_ICACHE_STATS_EN to add hit_count/miss_count outputs.
module inf_icache
   import inf_pkg::*;
#(
   parameter int unsigned SETS   = 64,
   parameter int unsigned ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ic_enable,
   input  logic [ADDR_W-1:0] iaddr,
   output line_t             idata,
   output logic              ic_done,
`ifdef INF_ICACHE_STATS_EN
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
`endif
   output logic              bus_reqcyc,
   output logic [ADDR_W-1:0] bus_req,
   output logic [12:0]       bus_reqtag,
   input  logic              bus_reqack,
   input  logic              bus_respcyc,
   input  logic [63:0]       bus_resp,
   output logic              bus_respack
);

   localparam int unsigned OFF_BITS   = $clog2(LINE_BYTES);
   localparam int unsigned INDEX_BITS = $clog2(SETS);
   localparam int unsigned TAG_W      = ADDR_W - OFF_BITS - INDEX_BITS;
   localparam int unsigned CNT_W      = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   icache_state_t         r_state, w_state_next;
   logic [INDEX_BITS-1:0] r_index, w_index_next;
   logic [TAG_W-1:0]      r_tag, w_tag_next;
   logic                  r_hit, w_hit_next;
   line_t                 r_buf, w_buf_next;
   logic [CNT_W-1:0]      r_cnt, w_cnt_next;
   line_t                 r_idata, w_idata_next;
   logic                  r_done, w_done_next;
   logic                  r_reqcyc, w_reqcyc_next;
   logic [ADDR_W-1:0]     r_req, w_req_next;

   logic [INDEX_BITS-1:0] w_in_index;
   logic [TAG_W-1:0]      w_in_tag;
   line_t                 w_rd_line;
   logic [TAG_W-1:0]      w_rd_tag;
   logic                  w_rd_valid;
   logic                  w_we;
   logic                  w_unused_addr;

   assign w_in_index    = iaddr[OFF_BITS +: INDEX_BITS];
   assign w_in_tag      = iaddr[ADDR_W-1 -: TAG_W];
   assign w_unused_addr = ^iaddr[OFF_BITS-1:0];

   // Reads are addressed straight from iaddr so a hit can answer in the LOOKUP cycle.
   inf_icache_array #(
      .SETS       (SETS),
      .TAG_W      (TAG_W),
      .INDEX_BITS (INDEX_BITS)
   ) u_array (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_rd_index (w_in_index),
      .o_rd_line  (w_rd_line),
      .o_rd_tag   (w_rd_tag),
      .o_rd_valid (w_rd_valid),
      .i_we       (w_we),
      .i_wr_index (r_index),
      .i_wr_line  (r_buf),
      .i_wr_tag   (r_tag)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_index  <= '0;
         r_tag    <= '0;
         r_hit    <= 1'b0;
         r_buf    <= '0;
         r_cnt    <= '0;
         r_idata  <= '0;
         r_done   <= 1'b0;
         r_reqcyc <= 1'b0;
         r_req    <= '0;
      end else begin
         r_state  <= w_state_next;
         r_index  <= w_index_next;
         r_tag    <= w_tag_next;
         r_hit    <= w_hit_next;
         r_buf    <= w_buf_next;
         r_cnt    <= w_cnt_next;
         r_idata  <= w_idata_next;
         r_done   <= w_done_next;
         r_reqcyc <= w_reqcyc_next;
         r_req    <= w_req_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_index_next  = r_index;
      w_tag_next    = r_tag;
      w_hit_next    = r_hit;
      w_buf_next    = r_buf;
      w_cnt_next    = r_cnt;
      w_idata_next  = r_idata;
      w_done_next   = 1'b0;
      w_reqcyc_next = r_reqcyc;
      w_req_next    = r_req;
      w_we          = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (ic_enable) begin
               w_index_next = w_in_index;
               w_tag_next   = w_in_tag;
               w_hit_next   = w_rd_valid && (w_rd_tag == w_in_tag);
               if (w_hit_next) begin
                  w_idata_next = w_rd_line;
                  w_done_next  = 1'b1;
               end
               w_state_next = LOOKUP;
            end
         end
         LOOKUP: begin
            if (r_hit) begin
               w_state_next = IDLE;
            end else begin
               w_reqcyc_next = 1'b1;
               w_req_next    = {r_tag, r_index, {OFF_BITS{1'b0}}};
               w_state_next  = FILL_REQ;
            end
         end
         FILL_REQ: begin
            if (bus_reqack) begin
               w_reqcyc_next = 1'b0;
               w_cnt_next    = '0;
               w_state_next  = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            if (bus_respcyc) begin
               w_buf_next[{r_cnt, 6'd0} +: 64] = bus_resp;
               w_cnt_next = r_cnt + 1'b1;
               // Response registers load with the final beat so ic_done lines up with FILL_DONE.
               if (r_cnt == LAST_BEAT) begin
                  w_idata_next = w_buf_next;
                  w_done_next  = 1'b1;
                  w_state_next = FILL_DONE;
               end
            end
         end
         FILL_DONE: begin
            w_we         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign idata       = r_idata;
   assign ic_done     = r_done;
   assign bus_reqcyc  = r_reqcyc;
   assign bus_req     = r_req;
   assign bus_reqtag  = REQTAG_IFETCH;
   assign bus_respack = (r_state == FILL_WAIT) && bus_respcyc;

`ifdef INF_ICACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (r_state == LOOKUP) begin
         if (r_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
         end else begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_inf_icache.sv
// Scoreboard bench for inf_icache: a line-level cache model predicts hits, bus requests and data.
`timescale 1ns/1ps
module tb_inf_icache;
   import inf_pkg::*;

   localparam int unsigned SETS   = 64;
   localparam int unsigned ADDR_W = 64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ic_enable = 1'b0;
   logic [63:0] iaddr = '0;
   line_t       idata;
   logic        ic_done;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack = 1'b0;
   logic        bus_respcyc = 1'b0;
   logic [63:0] bus_resp = '0;
   logic        bus_respack;
`ifdef INF_ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   inf_icache #(
      .SETS   (SETS),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ic_enable   (ic_enable),
      .iaddr       (iaddr),
      .idata       (idata),
      .ic_done     (ic_done),
`ifdef INF_ICACHE_STATS_EN
      .hit_count   (hit_count),
      .miss_count  (miss_count),
`endif
      .bus_reqcyc  (bus_reqcyc),
      .bus_req     (bus_req),
      .bus_reqtag  (bus_reqtag),
      .bus_reqack  (bus_reqack),
      .bus_respcyc (bus_respcyc),
      .bus_resp    (bus_resp),
      .bus_respack (bus_respack)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      tests++;
      fails++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Backing memory: one random line per line number, created on first touch.
   line_t mem [logic [57:0]];
   function automatic line_t get_line(input logic [57:0] ln);
      line_t l;
      if (!mem.exists(ln)) begin
         for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
         mem[ln] = l;
      end
      return mem[ln];
   endfunction

   // Reference model: which line number is resident in each set.
   typedef struct {
      line_t data;
      bit    hit;
      int    issue;
   } exp_t;

   logic [57:0] res [int];
   exp_t        sb [$];
   logic [63:0] bus_q [$];
   int          exp_hits = 0;
   int          exp_misses = 0;
   int          done_cnt = 0;

   int  ack_lo = 0, ack_hi = 3, gap_lo = 0, gap_hi = 2;
   bit  manual_bus = 1'b0;
   bit  in_beats = 1'b0;

   task automatic issue(input logic [63:0] a);
      logic [57:0] ln;
      int          idx;
      exp_t        e;
      ln      = a[63:6];
      idx     = int'(ln % SETS);
      e.hit   = res.exists(idx) && (res[idx] == ln);
      e.data  = get_line(ln);
      e.issue = cyc;
      if (e.hit) begin
         exp_hits++;
      end else begin
         exp_misses++;
         bus_q.push_back({ln, 6'd0});
         res[idx] = ln;
      end
      sb.push_back(e);
      ic_enable = 1'b1;
      iaddr     = a;
      @(posedge clk); #1;
      ic_enable = 1'b0;
   endtask

   // Returns at posedge+1 of the cycle after ic_done; noise pulses ic_enable while busy.
   task automatic wait_done(input int start, input bit noise);
      int n;
      n = 0;
      @(negedge clk); #1;
      while (done_cnt == start && n < 300) begin
         @(posedge clk); #1;
         if (noise) begin
            ic_enable = ($urandom_range(0, 5) == 0);
            iaddr     = {$urandom, $urandom};
         end
         @(negedge clk); #1;
         n++;
      end
      ic_enable = 1'b0;
      if (done_cnt == start) begin
         flag("done_timeout");
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic request(input logic [63:0] a, input bit noise);
      int start;
      start = done_cnt;
      issue(a);
      wait_done(start, noise);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ic_done"}, ic_done, 1'b0);
      chk({tag, "_idata"}, idata, '0);
      chk({tag, "_bus_reqcyc"}, bus_reqcyc, 1'b0);
      chk({tag, "_bus_req"}, bus_req, '0);
      chk({tag, "_bus_respack"}, bus_respack, 1'b0);
   endtask

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && ic_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               flag("spurious_ic_done");
            end else begin
               e = sb.pop_front();
               chk("idata", idata, e.data);
               if (e.hit) chk("hit_latency", cyc, e.issue + 1);
            end
         end
      end
   end

   // Bus monitor
   initial begin
      bit          prev = 1'b0;
      logic [63:0] cur = '0;
      forever begin
         @(negedge clk);
         if (reset_n && bus_reqcyc) begin
            if (!prev) begin
               if (bus_q.size() == 0) flag("unexpected_bus_req");
               else cur = bus_q.pop_front();
               chk("bus_reqtag", bus_reqtag, REQTAG_IFETCH);
            end
            chk("bus_req", bus_req, cur);
         end
         prev = reset_n && bus_reqcyc;
         if (reset_n && bus_respcyc) chk("bus_respack", bus_respack, in_beats);
      end
   end

   // Bus responder with random ack delay, beat gaps and stray response strobes while idle.
   initial begin
      logic [57:0] ln;
      line_t       l;
      int          n;
      forever begin
         @(posedge clk); #1;
         if (!manual_bus && reset_n && bus_reqcyc) begin
            bus_respcyc = 1'b0;
            ln = bus_req[63:6];
            n  = $urandom_range(ack_lo, ack_hi);
            repeat (n) begin @(posedge clk); #1; end
            bus_reqack = 1'b1;
            @(posedge clk); #1;
            bus_reqack = 1'b0;
            in_beats   = 1'b1;
            l = get_line(ln);
            for (int k = 0; k < 8; k++) begin
               n = $urandom_range(gap_lo, gap_hi);
               repeat (n) begin @(posedge clk); #1; end
               bus_respcyc = 1'b1;
               bus_resp    = l[k*64 +: 64];
               @(posedge clk); #1;
               bus_respcyc = 1'b0;
            end
            in_beats = 1'b0;
         end else if (!manual_bus && reset_n && $urandom_range(0, 9) == 0) begin
            bus_respcyc = 1'b1;
            bus_resp    = {$urandom, $urandom};
         end else if (!manual_bus) begin
            bus_respcyc = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      line_t       l;
      logic [57:0] ln;
      logic [63:0] a;
      int          n, start;

      // Power-on reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // Cold miss with beats 0..7
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = 64'(k);
      mem[58'h41] = l;
      request(64'h1040, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      chk("cold_idata_hold", idata, l);

      // Hit in the same line, then a conflicting line in the same set
      request(64'h107F, 1'b0);
      request(64'h2040, 1'b0);
`ifdef INF_ICACHE_STATS_EN
      chk("hit_count", hit_count, 32'd1);
      chk("miss_count", miss_count, 32'd2);
`endif
      request(64'h1040, 1'b0);
      request(64'h1040, 1'b0);

      // Slow bus: 5-cycle ack wait and bubbles between beats
      ack_lo = 5; ack_hi = 5; gap_lo = 1; gap_hi = 3;
      request(64'h5000, 1'b0);
      request(64'h5008, 1'b0);
      ack_lo = 0; ack_hi = 3; gap_lo = 0; gap_hi = 2;

      // Reset in the middle of a fill
      manual_bus = 1'b1;
      bus_respcyc = 1'b0;
      ln = 58'hC0;
      issue({ln, 6'd0});
      n = 0;
      while (!bus_reqcyc && n < 20) begin @(posedge clk); #1; n++; end
      if (!bus_reqcyc) flag("midfill_no_req");
      bus_reqack = 1'b1;
      @(posedge clk); #1;
      bus_reqack = 1'b0;
      in_beats   = 1'b1;
      l = get_line(ln);
      for (int k = 0; k < 4; k++) begin
         bus_respcyc = 1'b1;
         bus_resp    = l[k*64 +: 64];
         @(posedge clk); #1;
         bus_respcyc = 1'b0;
      end
      in_beats = 1'b0;
      reset_n  = 1'b0;
      res.delete();
      sb.delete();
      bus_q.delete();
      exp_hits = 0;
      exp_misses = 0;
      mem.delete(ln);
      @(negedge clk);
      check_reset_outputs("midfill_reset");
      @(posedge clk); #1;
      reset_n    = 1'b1;
      manual_bus = 1'b0;
      @(posedge clk); #1;
      request({ln, 6'd0}, 1'b0);
      request({ln, 6'h3C}, 1'b0);

      // Random traffic over a few sets and tags for hits, conflicts and back-to-back requests
      for (int r = 0; r < 150; r++) begin
         ln = 58'($urandom_range(0, 3)) * 58'(SETS) + 58'($urandom_range(0, 7));
         a  = {ln, 6'($urandom_range(0, 63))};
         n  = $urandom_range(0, 2);
         repeat (n) begin @(posedge clk); #1; end
         request(a, ($urandom_range(0, 3) == 0));
      end

      repeat (5) begin @(posedge clk); #1; end
      start = sb.size();
      chk("scoreboard_drained", 32'(start), 32'd0);
      chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
`ifdef INF_ICACHE_STATS_EN
      chk("final_hit_count", hit_count, 32'(exp_hits));
      chk("final_miss_count", miss_count, 32'(exp_misses));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
